// File: rtl/data_ram_pkg.sv
// Shared constants and types for the byte-addressed data RAM.
package data_ram_pkg;
  localparam int WORD_BYTES = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic {IDLE, CLEAR} state_e;
endpackage

// File: rtl/data_ram_if.sv
// CPU-side access bus for data_ram; b_* debug read port exists only with DATA_RAM_DUALPORT_EN.
interface data_ram_if #(parameter int ADDR_WIDTH = 12);
  logic                  req;
  logic                  we;
  logic [1:0]            size;
  logic                  sign_ext;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  busy;
  logic                  misalign;
`ifdef DATA_RAM_DUALPORT_EN
  logic [ADDR_WIDTH-3:0] b_addr;
  logic [31:0]           b_rdata;

  modport master (output req, we, size, sign_ext, addr, wdata, b_addr,
                  input  rdata, busy, misalign, b_rdata);
  modport slave  (input  req, we, size, sign_ext, addr, wdata, b_addr,
                  output rdata, busy, misalign, b_rdata);
`else
  modport master (output req, we, size, sign_ext, addr, wdata,
                  input  rdata, busy, misalign);
  modport slave  (input  req, we, size, sign_ext, addr, wdata,
                  output rdata, busy, misalign);
`endif
endinterface

// File: rtl/data_ram_align.sv
// Byte-lane steering: store byte enables / replicated lane data, misalign flag,
// and load extraction with sign/zero extension.
module data_ram_align
  import data_ram_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic        misalign,
  output logic [31:0] rdata_ext
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign misalign = (size == SIZE_RSVD) ||
                    (size == SIZE_HALF && addr_lo[0]) ||
                    (size == SIZE_WORD && addr_lo != 2'b00);

  assign byte_v = raw_word[{addr_lo, 3'b000} +: 8];
  assign half_v = raw_word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be        = 4'b0000;
    wlane     = wdata;
    rdata_ext = raw_word;
    case (size)
      SIZE_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wlane     = {4{wdata[7:0]}};
        rdata_ext = {{24{sign_ext & byte_v[7]}}, byte_v};
      end
      SIZE_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wlane     = {2{wdata[15:0]}};
        rdata_ext = {{16{sign_ext & half_v[15]}}, half_v};
      end
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
  end
endmodule

// File: rtl/data_ram.sv
// Byte-addressed data memory with sub-word loads/stores and a reset clear sweep.
// Optional async debug word-read port under DATA_RAM_DUALPORT_EN.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  data_ram_if.slave  bus
);
  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IDX_W;

  logic [31:0] mem [DEPTH];

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               clr_we;
  logic [IDX_W-1:0]   widx;
  logic [3:0]         be;
  logic [31:0]        wlane, raw_word, rdata_ext;
  logic               mis, idle, ld_ok, st_ok;

  assign widx     = bus.addr[ADDR_WIDTH-1:2];
  assign raw_word = mem[widx];

  data_ram_align u_align (
    .size      (bus.size),
    .addr_lo   (bus.addr[1:0]),
    .sign_ext  (bus.sign_ext),
    .wdata     (bus.wdata),
    .raw_word  (raw_word),
    .be        (be),
    .wlane     (wlane),
    .misalign  (mis),
    .rdata_ext (rdata_ext)
  );

  // Sweep clears one word per cycle; last word written when ptr == DEPTH-1.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        ptr_d  = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(DEPTH - 1)) state_d = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RST ? CLEAR : IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign idle  = (state_q == IDLE);
  assign ld_ok = idle && bus.req && !bus.we && !mis;
  assign st_ok = idle && bus.req &&  bus.we && !mis && !rst;

  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      mem[ptr_q] <= '0;
    end else if (st_ok) begin
      for (int i = 0; i < WORD_BYTES; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
    end
  end

  assign bus.rdata    = ld_ok ? rdata_ext : 32'h0;
  assign bus.busy     = (state_q == CLEAR);
  assign bus.misalign = mis;

`ifdef DATA_RAM_DUALPORT_EN
  assign bus.b_rdata = mem[bus.b_addr];
`endif
endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram (ADDR_WIDTH=6, 16 words) against an array model.
module tb_data_ram;
  localparam int AW    = 6;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  data_ram_if #(.ADDR_WIDTH(AW)) bus ();
  data_ram #(.ADDR_WIDTH(AW), .CLEAR_ON_RST(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic bit mis(input logic [1:0] sz, input int a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input int a, input bit sx);
    logic [31:0] w, v;
    if (mis(sz, a)) return 32'h0;
    w = model[a / 4];
    if (sz == 2'd2) return w;
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else begin
      v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic void model_store(input logic [1:0] sz, input int a, input logic [31:0] d);
    logic [31:0] m;
    int sh;
    if (mis(sz, a)) return;
    if (sz == 2'd2) begin
      model[a / 4] = d;
      return;
    end
    sh = (sz == 2'd0) ? 8 * (a % 4) : 16 * ((a % 4) / 2);
    m  = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
    model[a / 4] = (model[a / 4] & ~(m << sh)) | ((d & m) << sh);
  endfunction

  task automatic store(input logic [1:0] sz, input int a, input logic [31:0] d);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = sz; bus.addr = AW'(a); bus.wdata = d;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.we = 1'b0;
    model_store(sz, a, d);
  endtask

  task automatic setld(input logic [1:0] sz, input int a, input bit sx);
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = 1'b0; bus.size = sz; bus.addr = AW'(a); bus.sign_ext = sx;
    #2;
  endtask

  task automatic test_reset;
    int cnt;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b exp 1", bus.busy); end
    tests++; if (bus.misalign !== 1'b0) begin fails++; $display("FAIL reset_misalign: got %b exp 0", bus.misalign); end
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      if (cnt == 4) begin
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd2; bus.addr = '0; #1;
        tests++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL busy_rdata: got %h exp 0", bus.rdata); end
        bus.req = 1'b0;
      end
      @(posedge clk); #1; cnt++;
    end
    tests++; if (cnt != DEPTH) begin fails++; $display("FAIL sweep_len: got %0d exp %0d", cnt, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      setld(2'd2, 4 * i, 1'b0);
      tests++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL clr_word%0d: got %h exp 0", i, bus.rdata); end
    end
  endtask

  task automatic test_byte;
    store(2'd2, 8, 32'h12345678);
    setld(2'd0, 9, 1'b1);
    tests++; if (bus.rdata !== 32'h00000056) begin fails++; $display("FAIL lb_9: got %h exp 00000056", bus.rdata); end
    setld(2'd0, 11, 1'b1);
    tests++; if (bus.rdata !== 32'h00000012) begin fails++; $display("FAIL lb_b: got %h exp 00000012", bus.rdata); end
    store(2'd0, 10, 32'h000000F0);
    setld(2'd2, 8, 1'b0);
    tests++; if (bus.rdata !== 32'h12F05678) begin fails++; $display("FAIL lw_8: got %h exp 12F05678", bus.rdata); end
    setld(2'd0, 10, 1'b1);
    tests++; if (bus.rdata !== 32'hFFFFFFF0) begin fails++; $display("FAIL lb_a: got %h exp FFFFFFF0", bus.rdata); end
    setld(2'd0, 10, 1'b0);
    tests++; if (bus.rdata !== 32'h000000F0) begin fails++; $display("FAIL lbu_a: got %h exp 000000F0", bus.rdata); end
  endtask

  task automatic test_half;
    store(2'd2, 4, 32'hAAAA5555);
    store(2'd1, 6, 32'h00008001);
    setld(2'd1, 6, 1'b1);
    tests++; if (bus.rdata !== 32'hFFFF8001) begin fails++; $display("FAIL lh_6: got %h exp FFFF8001", bus.rdata); end
    setld(2'd1, 6, 1'b0);
    tests++; if (bus.rdata !== 32'h00008001) begin fails++; $display("FAIL lhu_6: got %h exp 00008001", bus.rdata); end
    setld(2'd2, 4, 1'b0);
    tests++; if (bus.rdata !== 32'h80015555) begin fails++; $display("FAIL lw_4: got %h exp 80015555", bus.rdata); end
  endtask

  task automatic test_misalign;
    store(2'd2, 5, 32'hFFFFFFFF);
    store(2'd1, 3, 32'hFFFFFFFF);
    store(2'd3, 4, 32'hFFFFFFFF);
    setld(2'd2, 5, 1'b0);
    tests++; if (bus.misalign !== 1'b1 || bus.rdata !== 32'h0) begin fails++; $display("FAIL mis_lw5: got %b/%h exp 1/0", bus.misalign, bus.rdata); end
    setld(2'd1, 3, 1'b1);
    tests++; if (bus.misalign !== 1'b1 || bus.rdata !== 32'h0) begin fails++; $display("FAIL mis_lh3: got %b/%h exp 1/0", bus.misalign, bus.rdata); end
    setld(2'd3, 4, 1'b0);
    tests++; if (bus.misalign !== 1'b1 || bus.rdata !== 32'h0) begin fails++; $display("FAIL mis_rsvd: got %b/%h exp 1/0", bus.misalign, bus.rdata); end
    setld(2'd2, 4, 1'b0);
    tests++; if (bus.rdata !== 32'h80015555) begin fails++; $display("FAIL mis_w4: got %h exp 80015555", bus.rdata); end
    setld(2'd2, 0, 1'b0);
    tests++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL mis_w0: got %h exp 0", bus.rdata); end
  endtask

  task automatic test_random;
    logic [1:0]  sz;
    int          a;
    bit          sx, wr;
    logic [31:0] d, e;
    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 4 * DEPTH - 1);
      sx = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) != 0);
      d  = $urandom;
      if (wr) begin
        bus.sign_ext = sx;
        store(sz, a, d);
      end else begin
        setld(sz, a, sx);
        e = exp_load(sz, a, sx);
        tests++; if (bus.misalign !== mis(sz, a) || bus.rdata !== e) begin
          fails++; $display("FAIL rnd_load sz=%0d a=%0d: got %b/%h exp %b/%h", sz, a, bus.misalign, bus.rdata, mis(sz, a), e);
        end
      end
    end
  endtask

  task automatic test_rst_mid_sweep;
    int cnt;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 3) begin
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd2; bus.addr = AW'(4); bus.wdata = 32'hDEADBEEF;
      end else bus.req = 1'b0;
      @(posedge clk); #1;
    end
    bus.req = 1'b0; bus.we = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL restart_busy: got %b exp 1", bus.busy); end
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      if (cnt == 5) begin
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd2; bus.addr = AW'(8); bus.wdata = 32'h5A5A5A5A;
      end
      @(posedge clk); #1; cnt++;
      if (cnt == 6) begin bus.req = 1'b0; bus.we = 1'b0; end
    end
    bus.req = 1'b0; bus.we = 1'b0;
    tests++; if (cnt != DEPTH) begin fails++; $display("FAIL restart_len: got %0d exp %0d", cnt, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      setld(2'd2, 4 * i, 1'b0);
      tests++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL restart_word%0d: got %h exp 0", i, bus.rdata); end
    end
  endtask

`ifdef DATA_RAM_DUALPORT_EN
  task automatic test_dualport;
    store(2'd2, 16, 32'hCAFEBABE);
    store(2'd2, 0, 32'h01020304);
    setld(2'd2, 0, 1'b0);
    bus.b_addr = 4'd4; #1;
    tests++; if (bus.b_rdata !== 32'hCAFEBABE) begin fails++; $display("FAIL dp_b: got %h exp CAFEBABE", bus.b_rdata); end
    tests++; if (bus.rdata !== 32'h01020304) begin fails++; $display("FAIL dp_a: got %h exp 01020304", bus.rdata); end
  endtask
`endif

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.sign_ext = 1'b0;
    bus.addr = '0; bus.wdata = '0;
`ifdef DATA_RAM_DUALPORT_EN
    bus.b_addr = '0;
`endif
    test_reset();
    test_byte();
    test_half();
    test_misalign();
    test_random();
    test_rst_mid_sweep();
`ifdef DATA_RAM_DUALPORT_EN
    test_dualport();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
